instruction_decode: RTL and testbench

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

---
 rtl/rv32i_pkg.sv | 59 +++++
 rtl/reg_file.sv | 45 ++++
 rtl/instruction_decode.sv | 218 +++++++++++++++++++++
 tb/tb_instruction_decode.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// RV32I decode constants shared by the ID stage.
// Holds the opcode values, the ALU operation codes driven on ALUControlE,
// the ResultSrcE encodings and the immediate-format selector, plus the
// immediate extraction helper used by instruction_decode.
package rv32i_pkg;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluXor   = 4'd4,
        AluSll   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluSlt   = 4'd8,
        AluSltu  = 4'd9,
        AluPassB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc1 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ImmI = 3'd0,
        ImmS = 3'd1,
        ImmB = 3'd2,
        ImmJ = 3'd3,
        ImmU = 3'd4
    } imm_src_e;

    // Sign-extended immediate for the given instruction format.
    function automatic logic [31:0] imm_ext(input logic [31:0] ir, input imm_src_e src);
        logic [31:0] imm;
        case (src)
            ImmI:    imm = {{20{ir[31]}}, ir[31:20]};
            ImmS:    imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            ImmB:    imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            ImmJ:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            ImmU:    imm = {ir[31:12], 12'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 integer register file with two combinational read ports and one
// write port. x0 reads as zero and discards writes. A write landing on the
// same clock edge as a read of that (nonzero) register is forwarded to the
// read port so the ID stage sees the value being retired.
// Ports: clk, rst (async, active-high); ra1_i/ra2_i read addresses,
// rd1_o/rd2_o read data; we_i/wa_i/wd_i write enable, address, data.
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];
    logic        wr_en;

    assign wr_en = we_i && (wa_i != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (ra1_i != 5'd0) begin
            rd1_o = (wr_en && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
        end
        if (ra2_i != 5'd0) begin
            rd2_o = (wr_en && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I instruction decode stage: combinational decode of IF_ID_IR, register
// file read (with writeback bypass) and the ID/EX pipeline register.
// Ports: clk, rst (async, active-high); IF_ID_IR/IF_ID_PC from fetch;
// RegWriteW/RdW/ResultW writeback; FlushE squashes the control bits of the
// instruction entering ID/EX; *E outputs are the registered ID/EX fields.
// Optional: define ID_ILLEGAL_DETECT_EN to add the IllegalE output.
// Undefined encodings decode with all control bits low.
module instruction_decode
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_ID_IR,
    input  logic [31:0] IF_ID_PC,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic        ALUSrcAE,
    output logic [1:0]  ResultSrcE,
    output logic [3:0]  ALUControlE,
    output logic [2:0]  Funct3E,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
`ifdef ID_ILLEGAL_DETECT_EN
    output logic        IllegalE,
`endif
    output logic [4:0]  Rs2E
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        f7_zero, f7_alt;
    logic        legal;
    logic        reg_write, mem_write, jump, branch, alu_src, alu_src_a;
    result_src_e result_src;
    alu_ctrl_e   alu_ctrl, alu_f3;
    imm_src_e    imm_src;
    logic [31:0] rd1, rd2;

    assign opcode  = IF_ID_IR[6:0];
    assign f3      = IF_ID_IR[14:12];
    assign f7      = IF_ID_IR[31:25];
    assign f7_zero = (f7 == 7'b0000000);
    assign f7_alt  = (f7 == 7'b0100000);

    reg_file u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (IF_ID_IR[19:15]),
        .ra2_i (IF_ID_IR[24:20]),
        .rd1_o (rd1),
        .rd2_o (rd2),
        .we_i  (RegWriteW),
        .wa_i  (RdW),
        .wd_i  (ResultW)
    );

    // ALU op shared by R-type and I-ALU; SUB is layered on for R-type only.
    always_comb begin
        alu_f3 = AluAdd;
        case (f3)
            3'b000:  alu_f3 = AluAdd;
            3'b001:  alu_f3 = AluSll;
            3'b010:  alu_f3 = AluSlt;
            3'b011:  alu_f3 = AluSltu;
            3'b100:  alu_f3 = AluXor;
            3'b101:  alu_f3 = f7[5] ? AluSra : AluSrl;
            3'b110:  alu_f3 = AluOr;
            default: alu_f3 = AluAnd;
        endcase
    end

    always_comb begin
        legal      = 1'b1;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        alu_src_a  = 1'b0;
        result_src = ResAlu;
        alu_ctrl   = AluAdd;
        imm_src    = ImmI;
        case (opcode)
            OpR: begin
                legal     = f7_zero || (f7_alt && ((f3 == 3'b000) || (f3 == 3'b101)));
                reg_write = 1'b1;
                alu_ctrl  = ((f3 == 3'b000) && f7[5]) ? AluSub : alu_f3;
            end
            OpImm: begin
                if (f3 == 3'b001)      legal = f7_zero;
                else if (f3 == 3'b101) legal = f7_zero || f7_alt;
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = alu_f3;
            end
            OpLoad: begin
                legal      = (f3 != 3'b011) && (f3[2:1] != 2'b11);
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = ResMem;
            end
            OpStore: begin
                legal     = (f3[2] == 1'b0) && (f3 != 3'b011);
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = ImmS;
            end
            OpBranch: begin
                legal    = (f3[2:1] != 2'b01);
                branch   = 1'b1;
                alu_ctrl = AluSub;
                imm_src  = ImmB;
            end
            OpJal: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                alu_src_a  = 1'b1;
                result_src = ResPc1;
                imm_src    = ImmJ;
            end
            OpJalr: begin
                legal      = (f3 == 3'b000);
                jump       = 1'b1;
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = ResPc1;
            end
            OpLui: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = AluPassB;
                imm_src   = ImmU;
            end
            OpAuipc: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_src_a = 1'b1;
                imm_src   = ImmU;
            end
            default: legal = 1'b0;
        endcase
        // Undefined or malformed encodings (including the all-zero bubble) become NOPs.
        if (!legal) begin
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            jump       = 1'b0;
            branch     = 1'b0;
            alu_src    = 1'b0;
            alu_src_a  = 1'b0;
            result_src = ResAlu;
            alu_ctrl   = AluAdd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUSrcAE    <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            Funct3E     <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
            RdE         <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
        end else begin
            // Flush only kills the side-effecting controls; data still flows.
            RegWriteE   <= reg_write & ~FlushE;
            MemWriteE   <= mem_write & ~FlushE;
            JumpE       <= jump & ~FlushE;
            BranchE     <= branch & ~FlushE;
            ALUSrcE     <= alu_src;
            ALUSrcAE    <= alu_src_a;
            ResultSrcE  <= result_src;
            ALUControlE <= alu_ctrl;
            Funct3E     <= f3;
            RD1E        <= rd1;
            RD2E        <= rd2;
            ImmExtE     <= imm_ext(IF_ID_IR, imm_src);
            PCE         <= IF_ID_PC;
            RdE         <= IF_ID_IR[11:7];
            Rs1E        <= IF_ID_IR[19:15];
            Rs2E        <= IF_ID_IR[24:20];
        end
    end

`ifdef ID_ILLEGAL_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IllegalE <= 1'b0;
        end else begin
            // The all-zero word is a bubble, not an illegal instruction.
            IllegalE <= ~legal & (IF_ID_IR != 32'h0) & ~FlushE;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios plus a
// randomized run checked against a behavioural RV32I decode model.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir, pc;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic        flush;

    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE;
    logic [4:0]  RdE, Rs1E, Rs2E;
`ifdef ID_ILLEGAL_DETECT_EN
    logic        IllegalE;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mregs [32];

    logic [157:0] all_out;
    assign all_out = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, ResultSrcE,
                      ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, RdE, Rs1E, Rs2E};

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk         (clk),
        .rst         (rst),
        .IF_ID_IR    (ir),
        .IF_ID_PC    (pc),
        .RegWriteW   (reg_write_w),
        .RdW         (rd_w),
        .ResultW     (result_w),
        .FlushE      (flush),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ALUSrcAE    (ALUSrcAE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .Funct3E     (Funct3E),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .RdE         (RdE),
        .Rs1E        (Rs1E),
`ifdef ID_ILLEGAL_DETECT_EN
        .IllegalE    (IllegalE),
`endif
        .Rs2E        (Rs2E)
    );

    typedef struct {
        logic        legal;
        logic        illegal;
        logic [3:0]  ctl;       // {RegWrite, MemWrite, Jump, Branch}
        logic [1:0]  res;
        logic [3:0]  alu;
        logic        src;
        logic        chk_src;
        logic        src_a;
        logic        chk_src_a;
        logic [31:0] imm;
        logic        chk_imm;
    } exp_t;

    // ALU code indexed by funct3 for the non-SUB/non-SRA case.
    function automatic logic [3:0] alu_of(input logic [2:0] f3);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        return tbl[f3];
    endfunction

    // Behavioural decode built from the ISA field definitions with arithmetic.
    function automatic exp_t model(input logic [31:0] w);
        exp_t        e;
        int unsigned op, f3, f7, s;
        op = w & 32'h7f;
        f3 = (w >> 12) & 7;
        f7 = w >> 25;
        s  = w >> 31;
        e = '{legal: 1'b1, illegal: 1'b0, ctl: 4'b0, res: 2'd0, alu: 4'd0, src: 1'b0,
              chk_src: 1'b1, src_a: 1'b0, chk_src_a: 1'b1, imm: 32'h0, chk_imm: 1'b1};
        case (op)
            32'h33: begin
                e.legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                e.ctl = 4'b1000; e.chk_imm = 1'b0;
                e.alu = alu_of(3'(f3));
                if (f7 == 32) e.alu = (f3 == 0) ? 4'd1 : 4'd7;
            end
            32'h13: begin
                e.legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
                e.ctl = 4'b1000; e.src = 1'b1;
                e.alu = (f3 == 5 && f7 == 32) ? 4'd7 : alu_of(3'(f3));
                e.imm = ((w >> 20) & 2047) - s * 2048;
            end
            32'h03: begin
                e.legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                e.ctl = 4'b1000; e.src = 1'b1; e.res = 2'd1;
                e.imm = ((w >> 20) & 2047) - s * 2048;
            end
            32'h23: begin
                e.legal = (f3 < 3);
                e.ctl = 4'b0100; e.src = 1'b1;
                e.imm = ((w >> 7) & 31) + ((w >> 25) & 63) * 32 - s * 2048;
            end
            32'h63: begin
                e.legal = (f3 != 2 && f3 != 3);
                e.ctl = 4'b0001; e.alu = 4'd1;
                e.imm = ((w >> 8) & 15) * 2 + ((w >> 25) & 63) * 32 + ((w >> 7) & 1) * 2048
                        - s * 4096;
            end
            32'h6f: begin
                e.ctl = 4'b1010; e.res = 2'd2; e.chk_src = 1'b0; e.chk_src_a = 1'b0;
                e.imm = ((w >> 21) & 1023) * 2 + ((w >> 20) & 1) * 2048
                        + ((w >> 12) & 255) * 4096 - s * 1048576;
            end
            32'h67: begin
                e.legal = (f3 == 0);
                e.ctl = 4'b1010; e.res = 2'd2; e.src = 1'b1;
                e.imm = ((w >> 20) & 2047) - s * 2048;
            end
            32'h37: begin
                e.ctl = 4'b1000; e.alu = 4'd10; e.src = 1'b1; e.chk_src_a = 1'b0;
                e.imm = w & 32'hfffff000;
            end
            32'h17: begin
                e.ctl = 4'b1000; e.src = 1'b1; e.src_a = 1'b1;
                e.imm = w & 32'hfffff000;
            end
            default: e.legal = 1'b0;
        endcase
        if (!e.legal) begin
            e.ctl = 4'b0;
            e.illegal = (w != 0);
        end
        return e;
    endfunction

    function automatic logic [31:0] read_model(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (reg_write_w && rd_w == a) return result_w;
        return mregs[a];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ir = 32'h00500093; pc = 32'h40; flush = 1'b0;
        reg_write_w = 1'b0; rd_w = '0; result_w = '0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        step(); step();
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", all_out);
        end
`ifdef ID_ILLEGAL_DETECT_EN
        n_tests++;
        if (IllegalE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_illegal: got %b, want 0", IllegalE);
        end
`endif
        rst = 1'b0;
    endtask

    // addi x1,x0,5 loaded on the first edge after reset release.
    task automatic test_addi;
        ir = 32'h00500093; pc = 32'h10;
        step();
        n_tests++;
        if ({RegWriteE, ALUSrcE, ALUControlE, ImmExtE, RdE, Rs1E, PCE} !==
            {1'b1, 1'b1, 4'd0, 32'd5, 5'd1, 5'd0, 32'h10}) begin
            n_fail++;
            $display("FAIL addi: got rw=%b src=%b alu=%0d imm=%h rd=%0d rs1=%0d pc=%h",
                     RegWriteE, ALUSrcE, ALUControlE, ImmExtE, RdE, Rs1E, PCE);
        end
    endtask

    task automatic test_bypass;
        reg_write_w = 1'b1; rd_w = 5'd1; result_w = 32'h1234; ir = 32'h002081B3; pc = 32'h14;
        step();
        mregs[1] = 32'h1234;
        n_tests++;
        if ({RD1E, RD2E, RdE, ALUSrcE, RegWriteE} !== {32'h1234, 32'h0, 5'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bypass: got rd1=%h rd2=%h rd=%0d src=%b rw=%b, want 1234 0 3 0 1",
                     RD1E, RD2E, RdE, ALUSrcE, RegWriteE);
        end
        reg_write_w = 1'b0; result_w = 32'h0;
        step();
        n_tests++;
        if (RD1E !== 32'h1234) begin
            n_fail++;
            $display("FAIL stored_x1: got %h, want 00001234", RD1E);
        end
    endtask

    task automatic test_x0;
        reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'hFFFFFFFF; ir = 32'h000001B3;
        step();
        n_tests++;
        if (RD1E !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_same_cycle: got %h, want 0", RD1E);
        end
        reg_write_w = 1'b0;
        step();
        n_tests++;
        if ({RD1E, RD2E} !== 64'h0) begin
            n_fail++;
            $display("FAIL x0_after_write: got %h %h, want 0 0", RD1E, RD2E);
        end
    endtask

    task automatic test_branch_flush;
        ir = 32'hFE000EE3; flush = 1'b0;
        step();
        n_tests++;
        if ({BranchE, ALUControlE, ImmExtE} !== {1'b1, 4'd1, 32'hFFFFFFFC}) begin
            n_fail++;
            $display("FAIL beq: got br=%b alu=%0d imm=%h, want 1 1 fffffffc",
                     BranchE, ALUControlE, ImmExtE);
        end
        flush = 1'b1;
        step();
        n_tests++;
        if ({BranchE, ImmExtE} !== {1'b0, 32'hFFFFFFFC}) begin
            n_fail++;
            $display("FAIL beq_flush: got br=%b imm=%h, want 0 fffffffc", BranchE, ImmExtE);
        end
        flush = 1'b0;
    endtask

    task automatic test_illegal;
        ir = 32'hFFFFFFFF;
        step();
        n_tests++;
        if ({RegWriteE, MemWriteE, JumpE, BranchE} !== 4'b0) begin
            n_fail++;
            $display("FAIL illegal_ctl: got %b, want 0000", {RegWriteE, MemWriteE, JumpE, BranchE});
        end
`ifdef ID_ILLEGAL_DETECT_EN
        n_tests++;
        if (IllegalE !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_flag: got %b, want 1", IllegalE);
        end
        flush = 1'b1;
        step();
        n_tests++;
        if (IllegalE !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_flush: got %b, want 0", IllegalE);
        end
        flush = 1'b0;
`endif
        ir = 32'h0;
        step();
        n_tests++;
        if ({RegWriteE, MemWriteE, JumpE, BranchE} !== 4'b0) begin
            n_fail++;
            $display("FAIL bubble_ctl: got %b, want 0000", {RegWriteE, MemWriteE, JumpE, BranchE});
        end
`ifdef ID_ILLEGAL_DETECT_EN
        n_tests++;
        if (IllegalE !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_flag: got %b, want 0", IllegalE);
        end
`endif
    endtask

    task automatic test_random;
        logic [6:0]  ops [9];
        logic [31:0] r;
        logic [31:0] exp_rd1, exp_rd2;
        exp_t        e;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            case ($urandom_range(0, 12))
                9:       ir = 32'h0;
                10:      ir = r;
                11:      ir = 32'hFFFFFFFF;
                default: ir = {r[31:7], ops[$urandom_range(0, 8)]};
            endcase
            // Bias funct7 towards the values that make R/I shifts legal.
            if ($urandom_range(0, 2) != 0) ir[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h0;
            pc          = $urandom;
            flush       = ($urandom_range(0, 5) == 0);
            reg_write_w = $urandom_range(0, 1);
            rd_w        = ($urandom_range(0, 2) == 0) ? ir[19:15] : 5'($urandom);
            result_w    = $urandom;
            e       = model(ir);
            exp_rd1 = read_model(ir[19:15]);
            exp_rd2 = read_model(ir[24:20]);
            if (flush) begin
                e.ctl     = 4'b0;
                e.illegal = 1'b0;
            end
            step();
            n_tests++;
            if ({RegWriteE, MemWriteE, JumpE, BranchE} !== e.ctl) begin
                n_fail++;
                $display("FAIL rand_ctl ir=%h fl=%b: got %b, want %b", ir, flush,
                         {RegWriteE, MemWriteE, JumpE, BranchE}, e.ctl);
            end
            n_tests++;
            if ({RD1E, RD2E, PCE, RdE, Rs1E, Rs2E, Funct3E} !==
                {exp_rd1, exp_rd2, pc, ir[11:7], ir[19:15], ir[24:20], ir[14:12]}) begin
                n_fail++;
                $display("FAIL rand_data ir=%h: got rd1=%h rd2=%h pc=%h, want %h %h %h",
                         ir, RD1E, RD2E, PCE, exp_rd1, exp_rd2, pc);
            end
`ifdef ID_ILLEGAL_DETECT_EN
            n_tests++;
            if (IllegalE !== e.illegal) begin
                n_fail++;
                $display("FAIL rand_illegal ir=%h: got %b, want %b", ir, IllegalE, e.illegal);
            end
`endif
            if (e.legal) begin
                n_tests++;
                if ({ResultSrcE, ALUControlE} !== {e.res, e.alu}) begin
                    n_fail++;
                    $display("FAIL rand_alu ir=%h: got res=%0d alu=%0d, want %0d %0d",
                             ir, ResultSrcE, ALUControlE, e.res, e.alu);
                end
                if (e.chk_src) begin
                    n_tests++;
                    if (ALUSrcE !== e.src) begin
                        n_fail++;
                        $display("FAIL rand_src ir=%h: got %b, want %b", ir, ALUSrcE, e.src);
                    end
                end
                if (e.chk_src_a) begin
                    n_tests++;
                    if (ALUSrcAE !== e.src_a) begin
                        n_fail++;
                        $display("FAIL rand_srca ir=%h: got %b, want %b", ir, ALUSrcAE, e.src_a);
                    end
                end
                if (e.chk_imm) begin
                    n_tests++;
                    if (ImmExtE !== e.imm) begin
                        n_fail++;
                        $display("FAIL rand_imm ir=%h: got %h, want %h", ir, ImmExtE, e.imm);
                    end
                end
            end
            if (reg_write_w && rd_w != 0) mregs[rd_w] = result_w;
        end
        flush = 1'b0; reg_write_w = 1'b0;
    endtask

    task automatic test_async_reset;
        reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'd7; ir = 32'h00000013;
        step();
        reg_write_w = 1'b0;
        ir = (32'd5 << 15) | (32'd6 << 7) | 32'h33;   // add x6,x5,x0
        step();
        n_tests++;
        if (RD1E !== 32'd7) begin
            n_fail++;
            $display("FAIL x5_before_reset: got %h, want 7", RD1E);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, want 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        step();
        n_tests++;
        if ({RD1E, RegWriteE, RdE} !== {32'd0, 1'b1, 5'd6}) begin
            n_fail++;
            $display("FAIL x5_after_reset: got rd1=%h rw=%b rd=%0d, want 0 1 6",
                     RD1E, RegWriteE, RdE);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_x0();
        test_branch_flush();
        test_illegal();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
